// File: rtl/digit_serial_addsub.sv
// Digit-serial adder/subtractor: DIGIT bits per cycle, NDIG = DWIDTH/DIGIT
// cycles per operation. There is a valid/ready handshake on both sides, and
// signed overflow is reported for both add and subtract.
module digit_serial_addsub #(
  parameter int DWIDTH = 8,
  parameter int DIGIT  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DWIDTH-1:0] in1,
  input  logic [DWIDTH-1:0] in2,
  input  logic              sub,
  input  logic              ivalid,
  output logic              iready,
  output logic [DWIDTH-1:0] Sum,
  output logic              Carry,
  output logic              Overflow,
  output logic              ovalid,
  input  logic              oready,
  output logic              busy
);

  localparam int NDIG = DWIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  // Reject digit sizes that do not tile the operand exactly.
  generate
    if (DIGIT < 1 || DIGIT > DWIDTH || (DWIDTH % DIGIT) != 0) begin : g_bad_param
      $error("digit_serial_addsub: DIGIT must divide DWIDTH and lie in 1..DWIDTH");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state_q, state_d;
  logic [DWIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic              cy_q, cy_d, cout_q, cout_d, ovf_q, ovf_d;
  logic [CW-1:0]     cnt_q, cnt_d;

  logic [DIGIT:0]          dsum;
  logic [DIGIT-1:0]        dig_s;
  logic                    dig_c, c_msb;
  logic [DWIDTH+DIGIT-1:0] sum_cat;

  // Narrow digit adder over the low digit of the shifting operands.
  always_comb begin
    dsum  = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]} + {{DIGIT{1'b0}}, cy_q};
    dig_s = dsum[DIGIT-1:0];
    dig_c = dsum[DIGIT];
    // Carry into the top bit of this digit, recovered from that bit's sum.
    c_msb = dsum[DIGIT-1] ^ a_q[DIGIT-1] ^ b_q[DIGIT-1];
    // The new digit enters at the MSB end as the result shifts right.
    sum_cat = {dig_s, sum_q};
  end

  // Next-state and datapath updates; registers hold their value by default.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cy_d    = cy_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (ivalid) begin
          a_d     = in1;
          // Subtract as A + ~B + 1, with the +1 injected as the initial carry.
          b_d     = sub ? ~in2 : in2;
          cy_d    = sub;
          cnt_d   = CW'(NDIG - 1);
          sum_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        cy_d  = dig_c;
        sum_d = sum_cat[DWIDTH+DIGIT-1:DIGIT];
        a_d   = a_q >> DIGIT;
        b_d   = b_q >> DIGIT;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          cout_d  = dig_c;
          ovf_d   = c_msb ^ dig_c;
          state_d = DONE;
        end
      end
      DONE: begin
        if (oready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cy_q    <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cy_q    <= cy_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  assign iready   = (state_q == IDLE);
  assign ovalid   = (state_q == DONE);
  assign busy     = (state_q != IDLE);
  assign Sum      = sum_q;
  assign Carry    = cout_q;
  assign Overflow = ovf_q;

endmodule

// File: doc/digit_serial_addsub.md
Name: digit_serial_addsub

Overview:
- Parametrised digit-serial adder/subtractor. It consumes DIGIT bits per cycle from two DWIDTH-bit operands, so one operation takes DWIDTH/DIGIT cycles.
- Adds a subtract mode, signed overflow detection and a valid/ready handshake on both sides.
- Sits between a register-file/stream source and a result consumer in area-constrained datapaths. Trades latency for a narrow DIGIT-bit adder.

Parameters:
- DWIDTH, 8, operand and result width in bits.
- DIGIT, 2, bits processed per cycle. Must satisfy 1 <= DIGIT <= DWIDTH and DWIDTH % DIGIT == 0; elaboration fails otherwise.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous reset, active-high.
- in1  input  DWIDTH  operand A.
- in2  input  DWIDTH  operand B.
- sub  input  1  0: A+B, 1: A-B. Sampled with operands.
- ivalid  input  1  operands/sub valid.
- iready  output  1  block can accept an operation.
- Sum  output  DWIDTH  result (mod 2^DWIDTH).
- Carry  output  1  add: carry-out; sub: 1 = no borrow (A >= B unsigned).
- Overflow  output  1  signed two's-complement overflow.
- ovalid  output  1  Sum/Carry/Overflow valid.
- oready  input  1  consumer accepts result.
- busy  output  1  operation in progress or result pending.

Behaviour:
- One clock; reset is synchronous and active-high.
- NDIG = DWIDTH/DIGIT. The digit counter width is $clog2(NDIG), minimum 1 bit.
- Reset: state=IDLE. Sum, Carry, Overflow and ovalid are 0; busy=0; iready=1 on the cycle after rst deasserts. rst has priority over every other input and aborts any operation in progress with no output.
- FSM IDLE -> RUN -> DONE -> IDLE:
  - IDLE: iready=1, busy=0. ivalid=1 at an edge accepts the operation:
    - load operand register A <= in1;
    - load operand register B <= in2, or ~in2 when sub=1;
    - carry register <= sub; counter <= NDIG-1; sum register cleared; go to RUN.
  - RUN: iready=0, busy=1. Each cycle, compute the DIGIT-bit sum {c, s} = A[DIGIT-1:0] + B[DIGIT-1:0] + carry register.
    - carry register <= c.
    - Sum register shifts right by DIGIT with s inserted at the MSB end.
    - A and B shift right by DIGIT, zero fill.
    - Counter decrements. The cycle with counter==0 is the last digit; the next state is DONE.
    - On the last digit, Overflow <= carry into the MSB XOR carry out of the MSB (computed inside the final digit) and Carry <= c.
  - DONE: ovalid=1, iready=0, busy=1. Sum, Carry and Overflow are held stable while oready=0. Transfer completes at an edge with oready=1, then go to IDLE (ovalid=0 next cycle).
- ivalid is ignored whenever iready=0; no buffering of a second operation.
- Latency: operation accepted at edge E0 -> ovalid=1 from edge E0+NDIG onward. Minimum spacing between accepts is NDIG+2 cycles (with oready held 1).
- Outputs Sum/Carry/Overflow change only during RUN and are meaningful only while ovalid=1.
- DIGIT==DWIDTH degenerates to a single-cycle RUN: ovalid 1 cycle after accept. DIGIT==1 gives a bit-serial adder with DWIDTH-cycle latency.
- Arithmetic is unsigned modulo 2^DWIDTH for Sum. Overflow applies signed interpretation for both add and sub.

Test Plan:
1. DWIDTH=8, DIGIT=2, add 200+100 -> ovalid exactly 4 cycles after accept; Sum=44, Carry=1, Overflow=0.
2. Add 100+50 -> Sum=150, Carry=0, Overflow=1. Then sub 5-7 -> Sum=254, Carry=0, Overflow=0. Then sub 0x80-0x01 -> Sum=0x7F, Carry=1, Overflow=1.
3. Backpressure: hold oready=0 for 5 cycles in DONE while toggling ivalid and in1/in2 -> ovalid stays 1, outputs unchanged, iready=0, no new accept. Release oready -> IDLE, iready=1 next cycle.
4. Reset mid-RUN (rst on the 2nd RUN cycle) -> next cycle state IDLE, ovalid=0, busy=0, Sum=0, Carry=0, Overflow=0. Then a fresh 0xFF+0x01 -> Sum=0x00, Carry=1, Overflow=0.
5. Parameter sweep of DIGIT in {1, 2, 4, 8} with DWIDTH=8, plus DWIDTH=16/DIGIT=4, using 1000 random add/sub ops with random oready stalls -> every result matches the reference model; latency is NDIG cycles.
6. Back-to-back: ivalid held 1 continuously with oready=1 -> exactly one accept per NDIG+2 cycles; busy deasserts only in IDLE.
